bpsk_symbol_mapper: RTL

BPSK_SYMBOL_MAPPER -- requirements
Module: bpsk_symbol_mapper

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bpsk_carrier_lut.sv | 24 ++
 rtl/bpsk_symbol_mapper.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and default parameters for the BPSK symbol mapper.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_FETCH
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHUNKS   = 4;
  localparam int DEF_SPS      = 8;
  localparam int DEF_SAMPLE_W = 8;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpsk_carrier_lut.sv
// Combinational sine table: one period of SPS samples, amplitude 2^(SAMPLE_W-1)-1.
module bpsk_carrier_lut #(
  parameter int SPS      = 8,
  parameter int SAMPLE_W = 8
) (
  input  logic [$clog2(SPS)-1:0]    phase,
  output logic signed [SAMPLE_W-1:0] value
);

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'((1 << (SAMPLE_W - 1)) - 1);

  logic signed [SAMPLE_W-1:0] table_w [SPS];

  // Symmetric amplitude keeps every entry negatable without overflow.
  for (genvar k = 0; k < SPS; k++) begin : g_entry
    localparam real RAW = AMP * $sin(2.0 * PI * real'(k) / real'(SPS));
    localparam int  VAL = (RAW >= 0.0) ? $rtoi(RAW + 0.5) : -$rtoi(0.5 - RAW);
    assign table_w[k] = SAMPLE_W'(VAL);
  end

  assign value = table_w[phase];

endmodule

// File: rtl/bpsk_symbol_mapper.sv
// Serialises chunks from an upstream parallel buffer into a BPSK carrier, LSB first.
module bpsk_symbol_mapper
  import bpsk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHUNKS   = DEF_CHUNKS,
  parameter int SPS      = DEF_SPS,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       read,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       bit_out,
  output logic                       busy,
  output logic                       done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int CW = cnt_w(CHUNKS);
  localparam int PW = $clog2(SPS);

  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic [PW-1:0] LAST_PH    = PW'(SPS - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              chunk_cnt_q, chunk_cnt_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic [WIDTH-1:0]           shreg_q, shreg_d;
  logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       bit_out_q, bit_out_d;
  logic                       read_q, read_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic signed [SAMPLE_W-1:0] lut_val;

  bpsk_carrier_lut #(
    .SPS      (SPS),
    .SAMPLE_W (SAMPLE_W)
  ) u_lut (
    .phase (phase_d),
    .value (lut_val)
  );

  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          chunk_cnt_d = '0;
          bit_cnt_d   = '0;
          phase_d     = '0;
        end
      end
      ST_LOAD: begin
        shreg_d = data_in;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == LAST_PH) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (chunk_cnt_q == LAST_CHUNK) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_FETCH: begin
        chunk_cnt_d = chunk_cnt_q + 1'b1;
        state_d     = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with the state.
  always_comb begin
    sample_valid_d = (state_d == ST_SEND);
    bit_out_d      = sample_valid_d & shreg_d[0];
    sample_out_d   = '0;
    if (sample_valid_d) begin
      sample_out_d = bit_out_d ? lut_val : -lut_val;
    end
    read_d = sample_valid_d && (phase_d == LAST_PH) && (bit_cnt_d == LAST_BIT);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      chunk_cnt_q    <= '0;
      bit_cnt_q      <= '0;
      phase_q        <= '0;
      shreg_q        <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      bit_out_q      <= 1'b0;
      read_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      chunk_cnt_q    <= chunk_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      phase_q        <= phase_d;
      shreg_q        <= shreg_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      bit_out_q      <= bit_out_d;
      read_q         <= read_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign bit_out      = bit_out_q;
  assign read         = read_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
